// File: rtl/mdu_sequencer.sv
// Iterative MULT/DIV sequencer with HI/LO ownership for the EX stage.
// One shared radix-2 datapath does shift-add multiply and restoring divide.
module mdu_sequencer #(
    parameter int ITER_PER_CYCLE = 1,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_rtype,
    input  logic [5:0]      ex_funct,
    input  logic            ex_flush,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] mf_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [5:0] LAST = 6'(32 / ITER_PER_CYCLE - 1);
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div0;

    logic        is_op;
    logic        is_hl;
    logic        sgn_rs;
    logic        sgn_rt;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [63:0] prod;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    assign is_op   = ex_valid & ex_rtype & (ex_funct[5:2] == 4'b0110);
    assign is_hl   = ex_valid & ex_rtype & (ex_funct[5:2] == 4'b0100);
    assign stall   = !ex_flush & (is_op | is_hl) & busy;
    assign mf_data = (ex_funct == F_MFHI) ? hi : lo;

    // Signed ops run on magnitudes; the sign flags restore the result in FIX.
    always_comb begin
        sgn_rs = !ex_funct[0] & rs_val[31];
        sgn_rt = !ex_funct[0] & rt_val[31];
        a_in   = sgn_rs ? -rs_val : rs_val;
        b_in   = sgn_rt ? -rt_val : rt_val;
    end

    always_comb begin
        prod   = neg_res ? -acc : acc;
        fix_hi = is_div ? (neg_rem ? -acc[63:32] : acc[63:32]) : prod[63:32];
        fix_lo = is_div ? (div0 ? 32'hFFFFFFFF : (neg_res ? -acc[31:0] : acc[31:0]))
                        : prod[31:0];
    end

    // Divide keeps remainder in acc[63:32] and shifts quotient bits into acc[31:0].
    function automatic logic [63:0] step(input logic [63:0] a, input logic div,
                                         input logic [31:0] d);
        logic [63:0] r;
        logic [32:0] sum;
        logic [32:0] diff;
        r = a;
        for (int i = 0; i < ITER_PER_CYCLE; i++) begin
            if (div) begin
                diff = r[63:31] - {1'b0, d};
                if (!diff[32]) r = {diff[31:0], r[30:0], 1'b1};
                else           r = {r[62:0], 1'b0};
            end else begin
                sum = {1'b0, r[63:32]} + (r[0] ? {1'b0, d} : 33'd0);
                r   = {sum, r[31:1]};
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_op && !ex_flush) begin
                        state   <= BUSY;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        is_div  <= ex_funct[1];
                        acc     <= {32'b0, (ex_funct[1] ? a_in : b_in)};
                        opnd    <= ex_funct[1] ? b_in : a_in;
                        neg_res <= sgn_rs ^ sgn_rt;
                        neg_rem <= sgn_rs;
                        div0    <= (rt_val == 32'b0);
                    end else if (is_hl && !ex_flush) begin
                        if (ex_funct == F_MTHI) hi <= rs_val;
                        if (ex_funct == F_MTLO) lo <= rs_val;
                    end
                end
                BUSY: begin
                    acc <= step(acc, is_div, opnd);
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed plan cases plus random
// MULT/DIV traffic compared against a 64-bit arithmetic reference model.
module tb_mdu_sequencer;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_rtype = 1'b0;
    logic [5:0]  ex_funct = '0;
    logic        ex_flush = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        stall;
    logic        busy;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int nvec = 0;
    int nfail = 0;

    mdu_sequencer #(.ITER_PER_CYCLE(1), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rtype(ex_rtype),
        .ex_funct(ex_funct), .ex_flush(ex_flush), .rs_val(rs_val), .rt_val(rt_val),
        .stall(stall), .busy(busy), .mf_data(mf_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the architectural operands.
    function automatic void ref_mdu(input logic [5:0] f, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] rh,
                                    output logic [31:0] rl);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (f == F_MULT) begin
            p = 64'(sa * sb);
        end else if (f == F_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
        end else if (b == 32'b0) begin
            p = {a, 32'hFFFFFFFF};
        end else if (f == F_DIV) begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
        end else begin
            p = {({32'b0, a} % {32'b0, b}), 32'b0} | ({32'b0, a} / {32'b0, b});
        end
        rh = p[63:32];
        rl = p[31:0];
    endfunction

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic flush);
        ex_valid = 1'b1;
        ex_rtype = 1'b1;
        ex_funct = f;
        rs_val   = a;
        rt_val   = b;
        ex_flush = flush;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        ex_flush = 1'b0;
        ex_funct = '0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] eh, el;
        int cyc;
        ref_mdu(f, a, b, eh, el);
        drive(f, a, b, 1'b0);
        @(posedge clk);
        #1;
        idle_inputs();
        wait_idle(cyc);
        nvec++;
        if (cyc !== LAT) begin
            nfail++;
            $display("[TB] FAIL %s latency: got %0d, want %0d", name, cyc, LAT);
        end
        nvec++;
        if (hi !== eh || lo !== el) begin
            nfail++;
            $display("[TB] FAIL %s result: got hi=%h lo=%h, want hi=%h lo=%h (rs=%h rt=%h)",
                     name, hi, lo, eh, el, a, b);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b0 || stall !== 1'b0 || hi !== 32'b0 || lo !== 32'b0) begin
            nfail++;
            $display("[TB] FAIL reset: got busy=%b stall=%b hi=%h lo=%h, want 0 0 0 0",
                     busy, stall, hi, lo);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_op("mult_7_m3", F_MULT, 32'd7, 32'hFFFFFFFD);
        run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("div_m7_2", F_DIV, 32'hFFFFFFF9, 32'd2);
        run_op("divu_by0", F_DIVU, 32'h1234, 32'd0);
        run_op("div_by0_neg", F_DIV, 32'h80000005, 32'd0);
        run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_op("div_neg_neg", F_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9);
    endtask

    task automatic test_random();
        logic [5:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            f = F_MULT + 6'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'b0;
                1: a = 32'h80000000;
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op("random", f, a, b);
        end
    endtask

    task automatic test_stall_mfhi();
        logic [31:0] eh, el;
        int n;
        ref_mdu(F_MULT, 32'h00012345, 32'hFFFF0001, eh, el);
        drive(F_MULT, 32'h00012345, 32'hFFFF0001, 1'b0);
        @(posedge clk);
        #1;
        drive(F_MFHI, 32'b0, 32'b0, 1'b0);
        n = 0;
        while (stall && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        nvec++;
        if (n !== LAT) begin
            nfail++;
            $display("[TB] FAIL mfhi_stall: stalled %0d cycles, want %0d", n, LAT);
        end
        nvec++;
        if (mf_data !== eh) begin
            nfail++;
            $display("[TB] FAIL mfhi_data: got %h, want %h", mf_data, eh);
        end
        idle_inputs();
    endtask

    task automatic test_add_no_stall();
        int cyc;
        drive(F_MULT, 32'd5, 32'd6, 1'b0);
        @(posedge clk);
        #1;
        drive(F_ADD, 32'd1, 32'd2, 1'b0);
        #1;
        nvec++;
        if (stall !== 1'b0 || busy !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL add_while_busy: got stall=%b busy=%b, want 0 1", stall, busy);
        end
        drive(F_MTHI, 32'd1, 32'd2, 1'b0);
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL mthi_while_busy: got stall=%b, want 1", stall);
        end
        idle_inputs();
        wait_idle(cyc);
        nvec++;
        if (lo !== 32'd30 || hi !== 32'd0) begin
            nfail++;
            $display("[TB] FAIL mult_after_mthi_stall: got hi=%h lo=%h, want 0 1e", hi, lo);
        end
    endtask

    task automatic test_mt_and_flush();
        logic [31:0] r;
        r = $urandom;
        drive(F_MTLO, 32'hA5A5A5A5, 32'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(F_MTHI, r, 32'b0, 1'b0);
        nvec++;
        if (lo !== 32'hA5A5A5A5) begin
            nfail++;
            $display("[TB] FAIL mtlo: got %h, want a5a5a5a5", lo);
        end
        @(posedge clk);
        #1;
        drive(F_MTLO, 32'h11111111, 32'b0, 1'b1);
        nvec++;
        if (hi !== r) begin
            nfail++;
            $display("[TB] FAIL mthi: got %h, want %h", hi, r);
        end
        @(posedge clk);
        #1;
        drive(F_MULT, 32'd9, 32'd9, 1'b1);
        nvec++;
        if (lo !== 32'hA5A5A5A5) begin
            nfail++;
            $display("[TB] FAIL mtlo_flushed: got %h, want a5a5a5a5", lo);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        nvec++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("[TB] FAIL mult_flushed: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h1, l1, h2, l2;
        int n, cyc;
        ref_mdu(F_MULTU, 32'hDEADBEEF, 32'h00C0FFEE, h1, l1);
        ref_mdu(F_DIV, 32'hFFFF0000, 32'd7, h2, l2);
        drive(F_MULTU, 32'hDEADBEEF, 32'h00C0FFEE, 1'b0);
        @(posedge clk);
        #1;
        drive(F_DIV, 32'hFFFF0000, 32'd7, 1'b0);
        n = 0;
        while (stall && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        nvec++;
        if (n !== LAT || hi !== h1 || lo !== l1) begin
            nfail++;
            $display("[TB] FAIL b2b_first: stall=%0d hi=%h lo=%h, want %0d %h %h",
                     n, hi, lo, LAT, h1, l1);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        wait_idle(cyc);
        nvec++;
        if (cyc !== LAT || hi !== h2 || lo !== l2) begin
            nfail++;
            $display("[TB] FAIL b2b_second: cyc=%0d hi=%h lo=%h, want %0d %h %h",
                     cyc, hi, lo, LAT, h2, l2);
        end
    endtask

    task automatic test_reset_mid();
        drive(F_DIV, 32'd1000, 32'd3, 1'b0);
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b0 || hi !== 32'b0 || lo !== 32'b0) begin
            nfail++;
            $display("[TB] FAIL reset_mid: got busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("mult_3_4_after_reset", F_MULT, 32'd3, 32'd4);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall_mfhi();
        test_add_no_stall();
        test_mt_and_flush();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Iterative multiply/divide controller for the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage, sequences a shared shift-add/restoring-subtract datapath over multiple cycles, and owns the HI/LO registers. It serves MFHI/MFLO/MTHI/MTLO and raises a pipeline stall when an instruction needs HI/LO or the unit while an operation is in flight. It sits beside the ALU in EX and is qualified by the R-type decode (ALUOp = 2'b10).

Parameters:
ITER_PER_CYCLE, 1, radix-2 iterations per busy cycle; legal values 1, 2, 4.
XLEN, 32, operand width; fixed at 32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  EX-stage instruction valid
ex_rtype  input  1  R-type decode (ALUOp == 2'b10)
ex_funct  input  6  instruction Funct field
ex_flush  input  1  squash EX instruction this cycle
rs_val  input  32  forwarded rs operand
rt_val  input  32  forwarded rt operand
stall  output  1  freeze IF/ID/EX; insert bubble into MEM
busy  output  1  operation in flight
mf_data  output  32  HI or LO value for MFHI/MFLO
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: async on rst_n low. State IDLE, hi = lo = 0, busy = 0, stall = 0, counter and internal operand/accumulator registers = 0. Reset mid-operation abandons the operation; no HI/LO write.
- Decoded Funct codes, recognised only when ex_valid & ex_rtype:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
- Groups: op = MULT/DIV class; hl = MF*/MT* class.
- Accept: in IDLE, op & !ex_flush. Latch |rs|, |rt| for signed ops, raw values for unsigned. Latch result-sign flags. Move to BUSY with counter = 0.
- BUSY:
  - Each cycle performs ITER_PER_CYCLE iterations.
  - Multiply: 64-bit shift-add.
  - Divide: restoring; remainder in the upper half, quotient in the lower half.
  - After 32/ITER_PER_CYCLE cycles, move to FIX.
- FIX: one cycle.
  - Apply sign correction. Signed multiply negates the 64-bit product when signs differ. Signed divide negates the quotient when signs differ and gives the remainder the dividend's sign.
  - Write {hi, lo} at the end of the cycle, then go to IDLE.
- Divide by zero (rt = 0), signed or unsigned: hi = rs_val as latched, lo = 32'hFFFFFFFF. Full latency still applies; no exception.
- Signed corner case: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. Wraps; no trap.
- busy = 1 in BUSY and FIX.
- Stall condition, combinational: stall = ex_valid & ex_rtype & !ex_flush & (op | hl) & busy.
  - Other instructions proceed while busy.
  - The result is visible in the cycle after FIX.
- Stall latency: total latency from accept to hi/lo valid is 32/ITER_PER_CYCLE + 1 cycles. An MFHI issued immediately after MULT (ITER = 1) stalls 33 cycles.
- MTHI/MTLO: when not stalled, write rs_val into hi/lo at the clock edge. Suppressed by ex_flush.
- mf_data: combinational; hi when funct = MFHI, else lo. Valid only when not stalled.
- An op arriving while busy is not accepted; it stalls and is accepted on the first IDLE cycle.
- ex_flush on an accept cycle prevents acceptance. An accepted operation is never cancelled by a later flush.
- No simultaneous accept and HI/LO write: op and hl are mutually exclusive by Funct.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3), ITER=1 -> busy for 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=0x1234, rt=0 -> hi=0x1234, lo=0xFFFFFFFF.
- MULT followed immediately by MFHI -> stall high exactly 33 cycles. MFHI then returns the product high word. An independent ADD after MULT sees no stall.
- MTLO rs=0xA5A5A5A5 while idle -> lo updated the next cycle. MULT with ex_flush=1 -> no accept, busy stays 0.
- rst_n low at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately. After release, a new MULT 3*4 gives lo=12.
